sa_core: RTL and testbench

//  Output-stationary ROWS x ROWS systolic matrix-multiply core (8-bit operands, 32-bit accumulators).
//  - Each accepted input beat k supplies an activation vector a_k[0..ROWS-1] (one per array row)
//    and a weight vector w_k[0..ROWS-1] (one per array column).
//  - PE(r,c) accumulates C[r][c] = sum_k a_k[r]*w_k[c] over one tile.
//  - The finished tile is drained one result row per handshake through a ROWS-lane output port.
//  - Sits between the operand feeders and the result writeback of the accelerator datapath.

---
 rtl/sa_pkg.sv | 21 ++
 rtl/sa_pe.sv | 66 ++++++
 rtl/sa_core.sv | 217 +++++++++++++++++++++
 tb/tb_sa_core.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the sa_core systolic matrix-multiply block.
//   DATA_W / ACC_W : operand and accumulator widths
//   data_t / acc_t : operand and accumulator types
//   mac()          : unsigned 8x8 multiply-accumulate, wrapping modulo 2^ACC_W
package sa_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 32;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [ACC_W-1:0]    acc_t;
  typedef logic [2*DATA_W-1:0] prod_t;

  // Product is formed at full 16-bit width before zero extension.
  function automatic acc_t mac(input acc_t acc, input data_t a, input data_t w);
    prod_t p;
    p = prod_t'(a) * prod_t'(w);
    return acc + acc_t'(p);
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Single processing element of the output-stationary array.
//   clk, rstn      : clock, asynchronous active-low reset
//   a_i, va_i      : activation and its valid from the west
//   w_i, vw_i      : weight and its valid from the north
//   clr_i          : tile snapshot taken this cycle; restart the accumulator
//   frz_i          : hold the accumulator (snapshot pending)
//   a_o, va_o      : registered activation/valid to the east
//   w_o, vw_o      : registered weight/valid to the south
//   acc_o          : running sum for this output element
module sa_pe
  import sa_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  data_t a_i,
  input  logic  va_i,
  input  data_t w_i,
  input  logic  vw_i,
  input  logic  clr_i,
  input  logic  frz_i,
  output data_t a_o,
  output logic  va_o,
  output data_t w_o,
  output logic  vw_o,
  output acc_t  acc_o
);

  data_t a_q, a_d, w_q, w_d;
  logic  va_q, va_d, vw_q, vw_d;
  acc_t  acc_q, acc_d;

  always_comb begin
    a_d   = a_i;
    w_d   = w_i;
    va_d  = va_i;
    vw_d  = vw_i;
    acc_d = clr_i ? '0 : acc_q;
    // A beat landing on the snapshot cycle starts the next tile's sum.
    if (va_i && vw_i && !frz_i) begin
      acc_d = mac(acc_d, a_i, w_i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q   <= '0;
      w_q   <= '0;
      va_q  <= 1'b0;
      vw_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      w_q   <= w_d;
      va_q  <= va_d;
      vw_q  <= vw_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign va_o  = va_q;
  assign w_o   = w_q;
  assign vw_o  = vw_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/sa_core.sv
// ROWS x ROWS output-stationary systolic matrix-multiply core.
//   clk, rstn   : clock, asynchronous active-low reset
//   ainport[r]  : activation for array row r
//   winport[c]  : weight for array column c
//   inpvalid    : beat valid; falling edge of a run of beats ends the tile
//   outread     : consumer pops the presented result row
//   routport[c] : C[ptr][c] of the presented row (registered)
//   rvalidport  : per-lane result valid, all bits equal
module sa_core
  import sa_pkg::*;
#(
  parameter int unsigned ROWS = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  data_t           ainport [ROWS],
  input  data_t           winport [ROWS],
  input  logic            inpvalid,
  input  logic            outread,
  output acc_t            routport [ROWS],
  output logic [0:ROWS-1] rvalidport
);

  localparam int unsigned CntW    = $clog2(2 * ROWS);
  localparam int unsigned PtrW    = $clog2(ROWS);
  localparam int unsigned SnapCnt = 2 * ROWS - 1;

  // Skewed array edge inputs.
  data_t a_sk [ROWS];
  data_t w_sk [ROWS];
  logic  va_sk [ROWS];
  logic  vw_sk [ROWS];

  // PE interconnect and results.
  data_t a_e  [ROWS][ROWS];
  data_t w_s  [ROWS][ROWS];
  logic  va_e [ROWS][ROWS];
  logic  vw_s [ROWS][ROWS];
  acc_t  acc_w [ROWS][ROWS];

  logic            beat, tile_end, due, pop, pop_last, fire, frz;
  logic            in_tile_q, in_tile_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            full_q, full_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  acc_t            obuf_q [ROWS][ROWS];
  acc_t            obuf_d [ROWS][ROWS];
  acc_t            rout_q [ROWS];
  acc_t            rout_d [ROWS];
  logic            rvalid_q, rvalid_d;

  // Beats are dropped while a snapshot is waiting for the buffer.
  assign beat = inpvalid && !pend_q;

  // Input skew: row r / column c see r+1 / c+1 register stages.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    data_t a_sr_q [r+1];
    data_t a_sr_d [r+1];
    data_t w_sr_q [r+1];
    data_t w_sr_d [r+1];
    logic  av_q [r+1];
    logic  av_d [r+1];
    logic  wv_q [r+1];
    logic  wv_d [r+1];

    always_comb begin
      a_sr_d[0] = ainport[r];
      w_sr_d[0] = winport[r];
      av_d[0]   = beat;
      wv_d[0]   = beat;
      for (int i = 1; i <= r; i++) begin
        a_sr_d[i] = a_sr_q[i-1];
        w_sr_d[i] = w_sr_q[i-1];
        av_d[i]   = av_q[i-1];
        wv_d[i]   = wv_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        a_sr_q <= '{default: '0};
        w_sr_q <= '{default: '0};
        av_q   <= '{default: 1'b0};
        wv_q   <= '{default: 1'b0};
      end else begin
        a_sr_q <= a_sr_d;
        w_sr_q <= w_sr_d;
        av_q   <= av_d;
        wv_q   <= wv_d;
      end
    end

    assign a_sk[r]  = a_sr_q[r];
    assign va_sk[r] = av_q[r];
    assign w_sk[r]  = w_sr_q[r];
    assign vw_sk[r] = wv_q[r];
  end

  // PE grid.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < ROWS; c++) begin : g_col
      data_t a_in, w_in;
      logic  va_in, vw_in;

      if (c == 0) begin : g_west
        assign a_in  = a_sk[r];
        assign va_in = va_sk[r];
      end else begin : g_inner_a
        assign a_in  = a_e[r][c-1];
        assign va_in = va_e[r][c-1];
      end

      if (r == 0) begin : g_north
        assign w_in  = w_sk[c];
        assign vw_in = vw_sk[c];
      end else begin : g_inner_w
        assign w_in  = w_s[r-1][c];
        assign vw_in = vw_s[r-1][c];
      end

      sa_pe u_pe (
        .clk   (clk),
        .rstn  (rstn),
        .a_i   (a_in),
        .va_i  (va_in),
        .w_i   (w_in),
        .vw_i  (vw_in),
        .clr_i (fire),
        .frz_i (frz),
        .a_o   (a_e[r][c]),
        .va_o  (va_e[r][c]),
        .w_o   (w_s[r][c]),
        .vw_o  (vw_s[r][c]),
        .acc_o (acc_w[r][c])
      );
    end
  end

  // Tile-end detection, snapshot timing and drain control.
  always_comb begin
    tile_end = in_tile_q && !inpvalid;
    in_tile_d = in_tile_q;
    if (beat) begin
      in_tile_d = 1'b1;
    end else if (tile_end) begin
      in_tile_d = 1'b0;
    end

    // cnt_q counts edges since the last beat; the last PE finishes one edge before due.
    due   = (cnt_q == SnapCnt[CntW-1:0]);
    cnt_d = cnt_q;
    if (tile_end) begin
      cnt_d = CntW'(1);
    end else if (due) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + 1'b1;
    end

    pop      = rvalid_q && outread;
    pop_last = pop && (ptr_q == PtrW'(ROWS - 1));

    // A due snapshot may share its edge with the final pop; a deferred one
    // waits until the buffer is empty.
    fire   = (due && (!full_q || pop_last)) || (pend_q && !full_q);
    pend_d = !fire && (pend_q || due);
    frz    = !fire && (pend_q || due);

    full_d = full_q;
    ptr_d  = ptr_q;
    obuf_d = obuf_q;
    if (pop) begin
      ptr_d = ptr_q + 1'b1;
      if (pop_last) begin
        full_d = 1'b0;
      end
    end
    if (fire) begin
      full_d = 1'b1;
      ptr_d  = '0;
      obuf_d = acc_w;
    end

    // Valid only once the buffer has been loaded for a full cycle.
    rvalid_d = full_q && full_d;
    for (int c = 0; c < ROWS; c++) begin
      rout_d[c] = rvalid_d ? obuf_d[ptr_d][c] : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_tile_q <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      full_q    <= 1'b0;
      ptr_q     <= '0;
      obuf_q    <= '{default: '0};
      rout_q    <= '{default: '0};
      rvalid_q  <= 1'b0;
    end else begin
      in_tile_q <= in_tile_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      full_q    <= full_d;
      ptr_q     <= ptr_d;
      obuf_q    <= obuf_d;
      rout_q    <= rout_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign routport   = rout_q;
  assign rvalidport = {ROWS{rvalid_q}};

endmodule

// File: tb/tb_sa_core.sv
module tb_sa_core;
  import sa_pkg::*;

  localparam int ROWS = 8;

  typedef struct {
    data_t a [ROWS];
    data_t w [ROWS];
    int    nb;
    acc_t  e00;
    acc_t  e77;
  } vec_t;

  logic            clk = 1'b0;
  logic            rstn;
  data_t           ain [ROWS];
  data_t           win [ROWS];
  logic            inpvalid;
  logic            outread;
  acc_t            rout [ROWS];
  logic [0:ROWS-1] rvp;

  int   total = 0;
  int   bad = 0;
  acc_t expm [ROWS][ROWS];
  vec_t tbl [4];
  vec_t hv;
  vec_t hv2;

  always #5 clk = ~clk;

  sa_core #(.ROWS(ROWS)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ainport    (ain),
    .winport    (win),
    .inpvalid   (inpvalid),
    .outread    (outread),
    .routport   (rout),
    .rvalidport (rvp)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic set_exp(input vec_t v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < ROWS; c++)
        expm[r][c] = acc_t'(v.nb) * acc_t'(v.a[r]) * acc_t'(v.w[c]);
  endtask

  // Entered and left on a negedge; inpvalid is low on exit.
  task automatic load(input vec_t v);
    for (int k = 0; k < v.nb; k++) begin
      ain = v.a;
      win = v.w;
      inpvalid = 1'b1;
      @(negedge clk);
    end
    inpvalid = 1'b0;
    ain = '{default: '0};
    win = '{default: '0};
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (rvp !== '1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(rvp === '1), 32'd1);
  endtask

  task automatic uniform(output vec_t v, input data_t a, input data_t w, input int nb);
    for (int i = 0; i < ROWS; i++) begin
      v.a[i] = a;
      v.w[i] = w;
    end
    v.nb = nb;
    v.e00 = '0;
    v.e77 = '0;
  endtask

  // Pops every row, checking each against expm plus two hand values.
  task automatic drain(input string nm, input acc_t h00, input acc_t h77);
    for (int r = 0; r < ROWS; r++) begin
      chk($sformatf("%s valid r%0d", nm, r), 32'(rvp), 32'hFF);
      for (int c = 0; c < ROWS; c++)
        chk($sformatf("%s r%0d c%0d", nm, r, c), rout[c], expm[r][c]);
      if (r == 0) chk($sformatf("%s hand00", nm), rout[0], h00);
      if (r == ROWS - 1) chk($sformatf("%s hand77", nm), rout[ROWS-1], h77);
      outread = 1'b1;
      @(negedge clk);
    end
    outread = 1'b0;
    chk($sformatf("%s valid_drop", nm), 32'(rvp), 32'd0);
  endtask

  initial begin
    // Vector table.
    for (int i = 0; i < ROWS; i++) begin
      tbl[0].a[i] = 8'd1;          tbl[0].w[i] = 8'd2;
      tbl[1].a[i] = data_t'(i + 1); tbl[1].w[i] = data_t'(i + 1);
      tbl[2].a[i] = 8'd255;        tbl[2].w[i] = 8'd255;
      tbl[3].a[i] = 8'd200;        tbl[3].w[i] = 8'd100;
    end
    tbl[0].nb = 16; tbl[0].e00 = 32'd32;    tbl[0].e77 = 32'd32;
    tbl[1].nb = 1;  tbl[1].e00 = 32'd1;     tbl[1].e77 = 32'd64;
    tbl[2].nb = 1;  tbl[2].e00 = 32'd65025; tbl[2].e77 = 32'd65025;
    tbl[3].nb = 2;  tbl[3].e00 = 32'd40000; tbl[3].e77 = 32'd40000;

    // 1. Reset and idle.
    rstn = 1'b0;
    inpvalid = 1'b0;
    outread = 1'b0;
    ain = '{default: '0};
    win = '{default: '0};
    #1;
    chk("reset valid", 32'(rvp), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle valid", 32'(rvp), 32'd0);
    for (int c = 0; c < ROWS; c++) chk($sformatf("idle out c%0d", c), rout[c], 32'd0);

    // 2. Table: exact latency then full drain.
    for (int t = 0; t < 4; t++) begin
      int early = 0;
      set_exp(tbl[t]);
      load(tbl[t]);
      for (int k = 1; k <= 2 * ROWS; k++) begin
        @(negedge clk);
        if (rvp !== '0) early++;
      end
      chk($sformatf("t%0d early_valid", t), 32'(early), 32'd0);
      @(negedge clk);
      chk($sformatf("t%0d latency", t), 32'(rvp), 32'hFF);
      drain($sformatf("t%0d", t), tbl[t].e00, tbl[t].e77);
      repeat (3) @(negedge clk);
    end

    // 3. Hold with outread low.
    uniform(hv, 8'd1, 8'd1, 1);
    set_exp(hv);
    load(hv);
    wait_valid("hold wait");
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k % 10 == 9) begin
        chk($sformatf("hold valid k%0d", k), 32'(rvp), 32'hFF);
        chk($sformatf("hold c3 k%0d", k), rout[3], 32'd1);
      end
    end
    drain("hold", 32'd1, 32'd1);

    // 4. Reset mid-drain, then a fresh tile.
    uniform(hv, 8'd2, 8'd2, 1);
    load(hv);
    wait_valid("rst wait");
    outread = 1'b1;
    repeat (3) @(negedge clk);
    outread = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst valid", 32'(rvp), 32'd0);
    for (int c = 0; c < ROWS; c++) chk($sformatf("rst out c%0d", c), rout[c], 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    uniform(hv, 8'd3, 8'd5, 1);
    set_exp(hv);
    load(hv);
    wait_valid("after rst wait");
    drain("after rst", 32'd15, 32'd15);

    // 5. Deferred snapshot: tile B completes while tile A is unread;
    //    a beat arriving while B is pending is dropped.
    uniform(hv, 8'd1, 8'd1, 1);
    uniform(hv2, 8'd4, 8'd4, 1);
    load(hv);
    wait_valid("defer A wait");
    load(hv2);
    repeat (22) @(negedge clk);
    uniform(hv, 8'd9, 8'd9, 1);
    load(hv);
    repeat (5) @(negedge clk);
    chk("defer A held", rout[0], 32'd1);
    uniform(hv, 8'd1, 8'd1, 1);
    set_exp(hv);
    drain("defer A", 32'd1, 32'd1);
    @(negedge clk);
    chk("defer gap", 32'(rvp), 32'd0);
    @(negedge clk);
    chk("defer B latency", 32'(rvp), 32'hFF);
    set_exp(hv2);
    drain("defer B", 32'd16, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
